tm1638_responder: RTL

TM1638_RESPONDER -- requirements
Module: tm1638_responder

---
 rtl/tm1638_responder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/tm1638_responder.sv
`timescale 1ns/1ps
// tm1638_responder: slave-side decoder for the TM1638 three-wire display
// protocol. Bytes arrive LSB first on dio, sampled on sclk rising edges
// while stb is low. The first byte of each frame is a command. Bytes after
// an address command are written into a 16-byte display RAM.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stb_in,
    input  logic         sclk_in,
    input  logic         dio_in,
    output logic [127:0] ram_flat,
    output logic         disp_on,
    output logic [2:0]   brightness,
    output logic         wr_valid,
    output logic [3:0]   wr_addr,
    output logic [7:0]   wr_data,
    output logic         cmd_valid,
    output logic [7:0]   cmd_byte,
    output logic         frame_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_e;

    // ---------------------------------------------------------------
    // Input synchronizers and edge detection
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
    logic                   stb_dly_q, stb_dly_d;
    logic                   sclk_dly_q, sclk_dly_d;
    // Fills with ones after reset. Stb edges are ignored until the chain has
    // flushed, so a stb held low through reset does not fake a falling edge.
    logic [SYNC_STAGES:0]   settle_q, settle_d;

    logic stb_s, sclk_s, dio_s, settled;
    logic stb_fall, stb_rise, sclk_rise;

    // Next values of the synchronizer chains and edge registers
    always_comb begin
        stb_sync_d  = {stb_sync_q[SYNC_STAGES-2:0], stb_in};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
        dio_sync_d  = {dio_sync_q[SYNC_STAGES-2:0], dio_in};
        stb_dly_d   = stb_sync_q[SYNC_STAGES-1];
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        settle_d    = {settle_q[SYNC_STAGES-1:0], 1'b1};
    end

    // Synchronizer and edge-detect registers; stb idles high
    // NOTE: every clocked block uses non-blocking assignments so all flops
    // sample the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stb_sync_q  <= '1;
            sclk_sync_q <= '0;
            dio_sync_q  <= '0;
            stb_dly_q   <= 1'b1;
            sclk_dly_q  <= 1'b0;
            settle_q    <= '0;
        end else begin
            stb_sync_q  <= stb_sync_d;
            sclk_sync_q <= sclk_sync_d;
            dio_sync_q  <= dio_sync_d;
            stb_dly_q   <= stb_dly_d;
            sclk_dly_q  <= sclk_dly_d;
            settle_q    <= settle_d;
        end
    end

    assign stb_s     = stb_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign dio_s     = dio_sync_q[SYNC_STAGES-1];
    assign settled   = settle_q[SYNC_STAGES];
    assign stb_fall  = settled & stb_dly_q & ~stb_s;
    assign stb_rise  = settled & ~stb_dly_q & stb_s;
    assign sclk_rise = ~sclk_dly_q & sclk_s;

    // ---------------------------------------------------------------
    // Protocol FSM, shift register, RAM and output registers
    // ---------------------------------------------------------------
    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [3:0]    addr_ptr_q, addr_ptr_d;
    logic          auto_inc_q, auto_inc_d;
    logic [127:0]  ram_q, ram_d;
    logic          disp_on_q, disp_on_d;
    logic [2:0]    brightness_q, brightness_d;
    logic          wr_valid_q, wr_valid_d;
    logic [3:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_byte_q, cmd_byte_d;
    logic          frame_err_q, frame_err_d;

    // Next-state, byte assembly and command/data decode
    // NOTE: every signal gets a default at the top so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        addr_ptr_d   = addr_ptr_q;
        auto_inc_d   = auto_inc_q;
        ram_d        = ram_q;
        disp_on_d    = disp_on_q;
        brightness_d = brightness_q;
        wr_valid_d   = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        frame_err_d  = frame_err_q;

        if (stb_fall) begin
            state_d   = CMD;
            bit_cnt_d = 3'd0;
            shift_d   = 8'h00;
        end else if (stb_rise) begin
            // Stb edge wins over a coincident sclk edge: that bit is dropped
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            if (bit_cnt_q != 3'd0)
                frame_err_d = 1'b1;
        end else if (sclk_rise && !stb_s && state_q != IDLE) begin
            shift_d[bit_cnt_q] = dio_s;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    CMD: begin
                        cmd_valid_d = 1'b1;
                        cmd_byte_d  = shift_d;
                        state_d     = IGNORE;
                        case (shift_d[7:6])
                            2'b01: begin
                                if (shift_d[1:0] == 2'b00)
                                    auto_inc_d = ~shift_d[2];
                                else
                                    frame_err_d = 1'b1;
                            end
                            2'b11: begin
                                addr_ptr_d = shift_d[3:0];
                                state_d    = DATA;
                            end
                            2'b10: begin
                                disp_on_d    = shift_d[3];
                                brightness_d = shift_d[2:0];
                            end
                            default: frame_err_d = 1'b1;
                        endcase
                    end
                    DATA: begin
                        ram_d[{addr_ptr_q, 3'b000} +: 8] = shift_d;
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_ptr_q;
                        wr_data_d  = shift_d;
                        if (auto_inc_q)
                            addr_ptr_d = addr_ptr_q + 4'd1;
                    end
                    default: frame_err_d = 1'b1;
                endcase
            end
        end
    end

    // State, datapath and output registers
    // NOTE: the display RAM is reset along with the control state because
    // it drives the panel directly and must come up blank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            addr_ptr_q   <= 4'd0;
            auto_inc_q   <= 1'b1;
            ram_q        <= '0;
            disp_on_q    <= 1'b0;
            brightness_q <= 3'd0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= 4'd0;
            wr_data_q    <= 8'h00;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'h00;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            addr_ptr_q   <= addr_ptr_d;
            auto_inc_q   <= auto_inc_d;
            ram_q        <= ram_d;
            disp_on_q    <= disp_on_d;
            brightness_q <= brightness_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign ram_flat   = ram_q;
    assign disp_on    = disp_on_q;
    assign brightness = brightness_q;
    assign wr_valid   = wr_valid_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign frame_err  = frame_err_q;

endmodule
